// File: rtl/inst_rom_boot_pkg.sv
// rtl/inst_rom_boot_pkg.sv - shared widths, nop word and boot state encodings
package inst_rom_boot_pkg;

    localparam int INST_BUS = 32;
    localparam logic [INST_BUS-1:0] ZERO_WORD = '0;

    typedef enum logic {
        BOOT_LOAD = 1'b0,
        BOOT_RUN  = 1'b1
    } boot_state_t;

endpackage

// File: rtl/inst_mem_array.sv
// rtl/inst_mem_array.sv - DEPTH x 32 storage, one synchronous write port, one asynchronous read port
module inst_mem_array
    import inst_rom_boot_pkg::*;
#(
    parameter int DEPTH  = 1024,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic                clk,
    input  logic                we,
    input  logic [ADDR_W-1:0]   waddr,
    input  logic [INST_BUS-1:0] wdata,
    input  logic [ADDR_W-1:0]   raddr,
    output logic [INST_BUS-1:0] rdata
);

    logic [INST_BUS-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/inst_rom_boot.sv
// rtl/inst_rom_boot.sv - boot-loaded instruction store holding the core in reset until loaded
// Optional running checksum of loaded words: INST_ROM_CHECKSUM_EN
module inst_rom_boot
    import inst_rom_boot_pkg::*;
#(
    parameter int DEPTH = 1024
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                load_valid_i,
    input  logic [INST_BUS-1:0] load_data_i,
    input  logic                load_last_i,
    output logic                load_ready_o,
    input  logic                rom_ce_i,
    input  logic [31:0]         rom_addr_i,
    output logic [INST_BUS-1:0] rom_data_o,
    output logic                cpu_rst_o,
    output logic                boot_done_o,
    output logic                overflow_o,
    output logic [INST_BUS-1:0] checksum_o
);

    localparam int ADDR_W = $clog2(DEPTH);

    boot_state_t         state;
    boot_state_t         state_next;
    logic [ADDR_W-1:0]   wptr;
    logic                accept;
    logic                at_end;
    logic [ADDR_W-1:0]   ridx;
    logic                out_of_range;
    logic [INST_BUS-1:0] rdata;
    logic                unused_byte_offset;

    // ready is only ever high in LOAD; rst gates a stale ready during the reset cycle
    assign accept = load_valid_i & load_ready_o & ~rst & (state == BOOT_LOAD);
    assign at_end = (wptr == ADDR_W'(DEPTH - 1));

    always_comb begin
        state_next = state;
        if (state == BOOT_LOAD && accept && (load_last_i || at_end)) begin
            state_next = BOOT_RUN;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= BOOT_LOAD;
            wptr         <= '0;
            load_ready_o <= 1'b0;
            cpu_rst_o    <= 1'b1;
            boot_done_o  <= 1'b0;
            overflow_o   <= 1'b0;
        end else begin
            state        <= state_next;
            load_ready_o <= (state_next == BOOT_LOAD);
            // core release lags the state change by one edge
            cpu_rst_o    <= (state != BOOT_RUN);
            boot_done_o  <= (state == BOOT_RUN);
            if (accept) begin
                wptr <= wptr + ADDR_W'(1);
                if (at_end && !load_last_i) begin
                    overflow_o <= 1'b1;
                end
            end
        end
    end

`ifdef INST_ROM_CHECKSUM_EN
    logic [INST_BUS-1:0] checksum;

    always_ff @(posedge clk) begin
        if (rst) begin
            checksum <= ZERO_WORD;
        end else if (accept) begin
            checksum <= checksum + load_data_i;
        end
    end

    assign checksum_o = checksum;
`else
    assign checksum_o = ZERO_WORD;
`endif

    inst_mem_array #(
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) u_mem (
        .clk   (clk),
        .we    (accept),
        .waddr (wptr),
        .wdata (load_data_i),
        .raddr (ridx),
        .rdata (rdata)
    );

    assign ridx               = rom_addr_i[ADDR_W+1:2];
    assign out_of_range       = |rom_addr_i[31:ADDR_W+2];
    assign unused_byte_offset = ^rom_addr_i[1:0];

    // out-of-range or gated fetches read as a nop
    always_comb begin
        rom_data_o = ZERO_WORD;
        if (rom_ce_i && !cpu_rst_o && !out_of_range) begin
            rom_data_o = rdata;
        end
    end

endmodule

// File: tb/tb_inst_rom_boot.sv
// tb/tb_inst_rom_boot.sv - directed self-checking bench for inst_rom_boot (DEPTH 1024 and DEPTH 4)
module tb_inst_rom_boot;

    logic        clk = 1'b0;
    logic        rst;
    logic        valid;
    logic [31:0] data;
    logic        last;
    logic        ready;
    logic        ce;
    logic [31:0] addr;
    logic [31:0] rdata;
    logic        cpu_rst;
    logic        done;
    logic        ovf;
    logic [31:0] csum;

    logic        rst4;
    logic        valid4;
    logic [31:0] data4;
    logic        last4;
    logic        ready4;
    logic        ce4;
    logic [31:0] addr4;
    logic [31:0] rdata4;
    logic        cpu_rst4;
    logic        done4;
    logic        ovf4;
    logic [31:0] csum4;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    inst_rom_boot dut (
        .clk          (clk),
        .rst          (rst),
        .load_valid_i (valid),
        .load_data_i  (data),
        .load_last_i  (last),
        .load_ready_o (ready),
        .rom_ce_i     (ce),
        .rom_addr_i   (addr),
        .rom_data_o   (rdata),
        .cpu_rst_o    (cpu_rst),
        .boot_done_o  (done),
        .overflow_o   (ovf),
        .checksum_o   (csum)
    );

    inst_rom_boot #(.DEPTH(4)) dut4 (
        .clk          (clk),
        .rst          (rst4),
        .load_valid_i (valid4),
        .load_data_i  (data4),
        .load_last_i  (last4),
        .load_ready_o (ready4),
        .rom_ce_i     (ce4),
        .rom_addr_i   (addr4),
        .rom_data_o   (rdata4),
        .cpu_rst_o    (cpu_rst4),
        .boot_done_o  (done4),
        .overflow_o   (ovf4),
        .checksum_o   (csum4)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // called at a negedge; returns at the negedge after the accepting edge
    task automatic send(input logic [31:0] d, input logic l);
        valid = 1'b1;
        data  = d;
        last  = l;
        @(posedge clk);
        @(negedge clk);
        valid = 1'b0;
        last  = 1'b0;
        data  = 32'hDEAD_0000;
    endtask

    task automatic idle();
        valid = 1'b0;
        data  = 32'hDEAD_0000;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic send4(input logic [31:0] d, input logic l);
        valid4 = 1'b1;
        data4  = d;
        last4  = l;
        @(posedge clk);
        @(negedge clk);
        valid4 = 1'b0;
        last4  = 1'b0;
    endtask

    task automatic rd(input logic [31:0] a, input string tag, input logic [31:0] exp);
        addr = a;
        #1;
        chk(tag, rdata, exp);
    endtask

    task automatic rd4(input logic [31:0] a, input string tag, input logic [31:0] exp);
        addr4 = a;
        #1;
        chk(tag, rdata4, exp);
    endtask

    logic [31:0] exp_sum;

    initial begin
        rst = 1'b1; valid = 1'b0; data = '0; last = 1'b0; ce = 1'b1; addr = '0;
        rst4 = 1'b1; valid4 = 1'b0; data4 = '0; last4 = 1'b0; ce4 = 1'b1; addr4 = '0;

        // 1. reset
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_cpu_rst", {31'b0, cpu_rst}, 32'd1);
        chk("rst_ready", {31'b0, ready}, 32'd0);
        chk("rst_done", {31'b0, done}, 32'd0);
        chk("rst_ovf", {31'b0, ovf}, 32'd0);
        chk("rst_rdata", rdata, 32'h0);
        chk("rst_csum", csum, 32'h0);

        // 2. basic boot
        rst = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk("ready_after_rst", {31'b0, ready}, 32'd1);
        send(32'h3401_1100, 1'b0);
        send(32'h3402_0020, 1'b0);
        send(32'h3403_ff00, 1'b1);
        chk("edgeN_ready", {31'b0, ready}, 32'd0);
        chk("edgeN_cpu_rst", {31'b0, cpu_rst}, 32'd1);
        chk("edgeN_done", {31'b0, done}, 32'd0);
        @(negedge clk);
        chk("edgeN1_cpu_rst", {31'b0, cpu_rst}, 32'd0);
        chk("edgeN1_done", {31'b0, done}, 32'd1);
        chk("boot_ovf", {31'b0, ovf}, 32'd0);
        rd(32'h8, "boot_w2", 32'h3403_ff00);
        rd(32'h0, "boot_w0", 32'h3401_1100);
`ifdef INST_ROM_CHECKSUM_EN
        exp_sum = 32'h9C07_1020;
`else
        exp_sum = 32'h0;
`endif
        chk("boot_csum", csum, exp_sum);
        // load stream ignored in RUN
        valid = 1'b1; data = 32'h1111_2222; last = 1'b1;
        @(posedge clk);
        @(negedge clk);
        valid = 1'b0; last = 1'b0;
        rd(32'h0, "run_ignore_w0", 32'h3401_1100);
        chk("run_ready", {31'b0, ready}, 32'd0);

        // 5. read gating and range
        ce = 1'b0;
        rd(32'h4, "ce_off", 32'h0);
        ce = 1'b1;
        rd(32'h1002, "out_of_range", 32'h0);
        rd(32'h6, "byte_offset", 32'h3402_0020);

        // 3. back-pressure: valid 1,0,0,1,1+last
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        @(negedge clk);
        send(32'hB000_0000, 1'b0);
        idle();
        idle();
        send(32'hB000_0001, 1'b0);
        send(32'hB000_0002, 1'b1);
        @(negedge clk);
        chk("bp_done", {31'b0, done}, 32'd1);
        rd(32'h0, "bp_w0", 32'hB000_0000);
        rd(32'h4, "bp_w1", 32'hB000_0001);
        rd(32'h8, "bp_w2", 32'hB000_0002);

        // 6. reset mid-LOAD, reboot one word
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        @(negedge clk);
        send(32'hC000_0000, 1'b0);
        send(32'hC000_0001, 1'b0);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("midload_ready", {31'b0, ready}, 32'd0);
        chk("midload_cpu_rst", {31'b0, cpu_rst}, 32'd1);
        rst = 1'b0;
        @(posedge clk);
        @(negedge clk);
        send(32'hAAAA_5555, 1'b1);
        @(negedge clk);
        chk("reboot_done", {31'b0, done}, 32'd1);
        rd(32'h0, "reboot_w0", 32'hAAAA_5555);
        rd(32'h4, "reboot_stale_w1", 32'hC000_0001);
`ifdef INST_ROM_CHECKSUM_EN
        exp_sum = 32'hAAAA_5555;
`else
        exp_sum = 32'h0;
`endif
        chk("reboot_csum", csum, exp_sum);

        // 4. overflow with DEPTH=4
        rst4 = 1'b0;
        @(posedge clk);
        @(negedge clk);
        send4(32'hA000_0000, 1'b0);
        send4(32'hA000_0001, 1'b0);
        send4(32'hA000_0002, 1'b0);
        chk("ovf_before_last_slot", {31'b0, ovf4}, 32'd0);
        send4(32'hA000_0003, 1'b0);
        chk("ovf_set", {31'b0, ovf4}, 32'd1);
        chk("ovf_ready", {31'b0, ready4}, 32'd0);
        @(negedge clk);
        chk("ovf_done", {31'b0, done4}, 32'd1);
        send4(32'hFFFF_FFFF, 1'b0);
        rd4(32'h0, "ovf_w0_kept", 32'hA000_0000);
        rd4(32'hC, "ovf_w3", 32'hA000_0003);
        rd4(32'h10, "ovf_range4", 32'h0);
        chk("ovf_sticky", {31'b0, ovf4}, 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
